// File: rtl/c7bbiu_rd_resp.sv
// BIU read-response path: routes AXI R beats by RID to IFU/LSU as registered
// one-cycle pulses, tracks outstanding reads per requester, flags protocol errors.
module c7bbiu_rd_resp #(
    parameter logic [3:0] RID_IFU   = 4'h0,
    parameter logic [3:0] RID_LSU   = 4'h1,
    parameter int         MAX_OUTST = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        axi_r_valid,
    output logic        axi_r_ready,
    input  logic [3:0]  axi_r_id,
    input  logic [31:0] axi_r_data,
    input  logic [1:0]  axi_r_resp,
    input  logic        axi_r_last,
    input  logic        biu_ifu_rd_ack,
    input  logic        biu_lsu_rd_ack,
    output logic        axi_rdata_ifu_val,
    output logic        axi_rdata_lsu_val,
    output logic        biu_ifu_rd_val,
    output logic [31:0] biu_ifu_rd_data,
    output logic        biu_ifu_rd_err,
    output logic        biu_lsu_rd_val,
    output logic [31:0] biu_lsu_rd_data,
    output logic        biu_lsu_rd_err,
    output logic        biu_ifu_rd_pend,
    output logic        biu_lsu_rd_pend,
    output logic        biu_rd_proto_err,
    input  logic        proto_err_clr
);

    localparam logic [1:0] MAX_CNT = MAX_OUTST[1:0];

    logic       r_ready_reg;
    logic       accept;
    logic       id_ifu;
    logic       id_lsu;
    logic [1:0] hit;
    logic [1:0] ack;
    logic [1:0] under;
    logic [1:0] over;
    logic       proto_set;
    logic       proto_err_reg;
    logic       proto_err_next;

    assign accept = axi_r_valid & r_ready_reg;
    assign id_ifu = (axi_r_id == RID_IFU);
    assign id_lsu = (axi_r_id == RID_LSU);
    // IFU wins when both IDs are configured identically
    assign hit[0] = accept & id_ifu;
    assign hit[1] = accept & id_lsu & ~id_ifu;
    assign ack    = {biu_lsu_rd_ack, biu_ifu_rd_ack};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_ready_reg <= 1'b0;
        else         r_ready_reg <= 1'b1;
    end

    // Index 0 is the IFU requester, index 1 the LSU requester
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_req
            logic [1:0]  cnt_reg;
            logic [1:0]  cnt_next;
            logic        under_next;
            logic        over_next;
            logic        val_reg;
            logic [31:0] data_reg;
            logic        err_reg;

            always_comb begin
                cnt_next   = cnt_reg;
                under_next = 1'b0;
                over_next  = 1'b0;
                case ({ack[gi], hit[gi]})
                    2'b10: begin
                        if (cnt_reg == MAX_CNT) over_next = 1'b1;
                        else                    cnt_next  = cnt_reg + 2'd1;
                    end
                    2'b01: begin
                        if (cnt_reg == 2'd0) under_next = 1'b1;
                        else                 cnt_next   = cnt_reg - 2'd1;
                    end
                    default: ;
                endcase
            end

            assign under[gi] = under_next;
            assign over[gi]  = over_next;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    cnt_reg  <= 2'd0;
                    val_reg  <= 1'b0;
                    data_reg <= 32'd0;
                    err_reg  <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    val_reg <= hit[gi];
                    if (hit[gi]) begin
                        data_reg <= axi_r_data;
                        err_reg  <= (axi_r_resp != 2'b00);
                    end
                end
            end
        end
    endgenerate

    assign proto_set = (accept & ~(id_ifu | id_lsu))
                     | (accept & ~axi_r_last)
                     | (|under) | (|over);
    assign proto_err_next = proto_set | (proto_err_reg & ~proto_err_clr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) proto_err_reg <= 1'b0;
        else         proto_err_reg <= proto_err_next;
    end

    assign axi_r_ready       = r_ready_reg;
    assign axi_rdata_ifu_val = hit[0];
    assign axi_rdata_lsu_val = hit[1];
    assign biu_ifu_rd_val    = gen_req[0].val_reg;
    assign biu_ifu_rd_data   = gen_req[0].data_reg;
    assign biu_ifu_rd_err    = gen_req[0].err_reg;
    assign biu_lsu_rd_val    = gen_req[1].val_reg;
    assign biu_lsu_rd_data   = gen_req[1].data_reg;
    assign biu_lsu_rd_err    = gen_req[1].err_reg;
    assign biu_ifu_rd_pend   = |gen_req[0].cnt_reg;
    assign biu_lsu_rd_pend   = |gen_req[1].cnt_reg;
    assign biu_rd_proto_err  = proto_err_reg;

endmodule

// File: tb/tb_c7bbiu_rd_resp.sv
// Directed bench for c7bbiu_rd_resp: stimulus pushes expected return pulses into
// per-port queues, a negedge monitor pops and compares them.
module tb_c7bbiu_rd_resp;

    logic        clk;
    logic        resetn;
    logic        axi_r_valid;
    logic        axi_r_ready;
    logic [3:0]  axi_r_id;
    logic [31:0] axi_r_data;
    logic [1:0]  axi_r_resp;
    logic        axi_r_last;
    logic        biu_ifu_rd_ack;
    logic        biu_lsu_rd_ack;
    logic        axi_rdata_ifu_val;
    logic        axi_rdata_lsu_val;
    logic        biu_ifu_rd_val;
    logic [31:0] biu_ifu_rd_data;
    logic        biu_ifu_rd_err;
    logic        biu_lsu_rd_val;
    logic [31:0] biu_lsu_rd_data;
    logic        biu_lsu_rd_err;
    logic        biu_ifu_rd_pend;
    logic        biu_lsu_rd_pend;
    logic        biu_rd_proto_err;
    logic        proto_err_clr;

    c7bbiu_rd_resp dut (
        .clk               (clk),
        .resetn            (resetn),
        .axi_r_valid       (axi_r_valid),
        .axi_r_ready       (axi_r_ready),
        .axi_r_id          (axi_r_id),
        .axi_r_data        (axi_r_data),
        .axi_r_resp        (axi_r_resp),
        .axi_r_last        (axi_r_last),
        .biu_ifu_rd_ack    (biu_ifu_rd_ack),
        .biu_lsu_rd_ack    (biu_lsu_rd_ack),
        .axi_rdata_ifu_val (axi_rdata_ifu_val),
        .axi_rdata_lsu_val (axi_rdata_lsu_val),
        .biu_ifu_rd_val    (biu_ifu_rd_val),
        .biu_ifu_rd_data   (biu_ifu_rd_data),
        .biu_ifu_rd_err    (biu_ifu_rd_err),
        .biu_lsu_rd_val    (biu_lsu_rd_val),
        .biu_lsu_rd_data   (biu_lsu_rd_data),
        .biu_lsu_rd_err    (biu_lsu_rd_err),
        .biu_ifu_rd_pend   (biu_ifu_rd_pend),
        .biu_lsu_rd_pend   (biu_lsu_rd_pend),
        .biu_rd_proto_err  (biu_rd_proto_err),
        .proto_err_clr     (proto_err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int miscompares = 0;

    // Expected return pulse: {err, data}
    logic [32:0] q_ifu[$];
    logic [32:0] q_lsu[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Monitor: every val pulse must match the oldest expected beat for that port
    always @(negedge clk) begin
        if (resetn) begin
            if (biu_ifu_rd_val) begin
                if (q_ifu.size() == 0) check("ifu_unexpected_pulse", 64'd1, 64'd0);
                else check("ifu_rd_beat", {31'd0, biu_ifu_rd_err, biu_ifu_rd_data}, {31'd0, q_ifu.pop_front()});
            end
            if (biu_lsu_rd_val) begin
                if (q_lsu.size() == 0) check("lsu_unexpected_pulse", 64'd1, 64'd0);
                else check("lsu_rd_beat", {31'd0, biu_lsu_rd_err, biu_lsu_rd_data}, {31'd0, q_lsu.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        axi_r_valid    = 1'b0;
        axi_r_id       = 4'h0;
        axi_r_data     = 32'h0;
        axi_r_resp     = 2'b00;
        axi_r_last     = 1'b1;
        biu_ifu_rd_ack = 1'b0;
        biu_lsu_rd_ack = 1'b0;
        proto_err_clr  = 1'b0;
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
        axi_r_valid = 1'b1;
        axi_r_id    = id;
        axi_r_data  = data;
        axi_r_resp  = resp;
        axi_r_last  = last;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        repeat (3) step();

        // Reset state
        check("reset_ready", {63'd0, axi_r_ready}, 64'd0);
        check("reset_outputs",
              {axi_rdata_ifu_val, axi_rdata_lsu_val, biu_ifu_rd_val, biu_ifu_rd_err,
               biu_lsu_rd_val, biu_lsu_rd_err, biu_ifu_rd_pend, biu_lsu_rd_pend,
               biu_rd_proto_err, biu_ifu_rd_data},
              64'd0);
        check("reset_lsu_data", {32'd0, biu_lsu_rd_data}, 64'd0);
        resetn = 1'b1;
        #1;
        check("ready_before_edge", {63'd0, axi_r_ready}, 64'd0);
        step();
        check("ready_after_release", {63'd0, axi_r_ready}, 64'd1);

        // Single IFU read
        biu_ifu_rd_ack = 1'b1;
        step();
        biu_ifu_rd_ack = 1'b0;
        check("ifu_pend_after_ack", {63'd0, biu_ifu_rd_pend}, 64'd1);
        beat(4'h0, 32'hDEADBEEF, 2'b00, 1'b1);
        #1;
        check("ifu_comb_val", {62'd0, axi_rdata_ifu_val, axi_rdata_lsu_val}, 64'd2);
        q_ifu.push_back({1'b0, 32'hDEADBEEF});
        step();
        idle();
        check("ifu_pend_cleared", {63'd0, biu_ifu_rd_pend}, 64'd1 - 64'd1);

        // Two LSU reads, back-to-back SLVERR beats
        biu_lsu_rd_ack = 1'b1;
        step();
        step();
        biu_lsu_rd_ack = 1'b0;
        beat(4'h1, 32'h11, 2'b10, 1'b1);
        #1;
        check("lsu_comb_val", {62'd0, axi_rdata_ifu_val, axi_rdata_lsu_val}, 64'd1);
        q_lsu.push_back({1'b1, 32'h11});
        step();
        check("lsu_pend_mid", {63'd0, biu_lsu_rd_pend}, 64'd1);
        beat(4'h1, 32'h22, 2'b10, 1'b1);
        q_lsu.push_back({1'b1, 32'h22});
        step();
        idle();
        check("lsu_pend_cleared", {63'd0, biu_lsu_rd_pend}, 64'd0);
        check("slverr_no_proto", {63'd0, biu_rd_proto_err}, 64'd0);

        // Unknown RID: dropped, error set, then cleared
        beat(4'h7, 32'h77, 2'b00, 1'b1);
        #1;
        check("bad_id_comb_val", {62'd0, axi_rdata_ifu_val, axi_rdata_lsu_val}, 64'd0);
        step();
        idle();
        check("bad_id_proto", {63'd0, biu_rd_proto_err}, 64'd1);
        proto_err_clr = 1'b1;
        step();
        proto_err_clr = 1'b0;
        check("proto_cleared", {63'd0, biu_rd_proto_err}, 64'd0);

        // Same-cycle ack and hit keeps the count
        biu_ifu_rd_ack = 1'b1;
        step();
        beat(4'h0, 32'hA5A5A5A5, 2'b00, 1'b1);
        q_ifu.push_back({1'b0, 32'hA5A5A5A5});
        step();
        idle();
        check("ack_hit_pend", {63'd0, biu_ifu_rd_pend}, 64'd1);
        check("ack_hit_no_proto", {63'd0, biu_rd_proto_err}, 64'd0);
        beat(4'h0, 32'h0000_1234, 2'b01, 1'b1);
        q_ifu.push_back({1'b1, 32'h0000_1234});
        step();
        check("drain_pend", {63'd0, biu_ifu_rd_pend}, 64'd0);
        check("drain_no_proto", {63'd0, biu_rd_proto_err}, 64'd0);

        // Underflow: delivered, error, counter held at 0
        beat(4'h0, 32'hCAFE0001, 2'b11, 1'b1);
        q_ifu.push_back({1'b1, 32'hCAFE0001});
        step();
        idle();
        check("underflow_proto", {63'd0, biu_rd_proto_err}, 64'd1);
        check("underflow_pend", {63'd0, biu_ifu_rd_pend}, 64'd0);
        proto_err_clr = 1'b1;
        biu_ifu_rd_ack = 1'b1;
        step();
        idle();
        check("post_underflow_pend", {63'd0, biu_ifu_rd_pend}, 64'd1);
        beat(4'h0, 32'h0BAD0000, 2'b00, 1'b1);
        q_ifu.push_back({1'b0, 32'h0BAD0000});
        step();
        idle();
        check("post_underflow_drain", {63'd0, biu_ifu_rd_pend}, 64'd0);
        check("post_underflow_proto", {63'd0, biu_rd_proto_err}, 64'd0);

        // Saturation at MAX_OUTST
        biu_ifu_rd_ack = 1'b1;
        repeat (3) step();
        check("three_acks_proto", {63'd0, biu_rd_proto_err}, 64'd0);
        step();
        biu_ifu_rd_ack = 1'b0;
        check("sat_proto", {63'd0, biu_rd_proto_err}, 64'd1);
        check("sat_pend", {63'd0, biu_ifu_rd_pend}, 64'd1);
        proto_err_clr = 1'b1;
        step();
        proto_err_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(4'h0, 32'h5000_0000 + 32'(i), 2'b00, 1'b1);
            q_ifu.push_back({1'b0, 32'h5000_0000 + 32'(i)});
            step();
            check("sat_drain_pend", {63'd0, biu_ifu_rd_pend}, (i < 2) ? 64'd1 : 64'd0);
        end
        idle();
        check("sat_drain_proto", {63'd0, biu_rd_proto_err}, 64'd0);

        // RLAST=0 still delivers but flags an error
        biu_lsu_rd_ack = 1'b1;
        step();
        biu_lsu_rd_ack = 1'b0;
        beat(4'h1, 32'h33, 2'b00, 1'b0);
        q_lsu.push_back({1'b0, 32'h33});
        step();
        idle();
        check("nolast_proto", {63'd0, biu_rd_proto_err}, 64'd1);
        check("nolast_pend", {63'd0, biu_lsu_rd_pend}, 64'd0);

        // Set wins over clear in the same cycle
        beat(4'h9, 32'h99, 2'b00, 1'b1);
        proto_err_clr = 1'b1;
        step();
        idle();
        check("set_wins_clr", {63'd0, biu_rd_proto_err}, 64'd1);
        proto_err_clr = 1'b1;
        step();
        proto_err_clr = 1'b0;
        check("clr_alone", {63'd0, biu_rd_proto_err}, 64'd0);

        // Asynchronous reset mid-operation
        biu_lsu_rd_ack = 1'b1;
        step();
        biu_lsu_rd_ack = 1'b0;
        beat(4'hE, 32'hEE, 2'b00, 1'b1);
        step();
        idle();
        check("pre_areset_pend", {63'd0, biu_lsu_rd_pend}, 64'd1);
        check("pre_areset_proto", {63'd0, biu_rd_proto_err}, 64'd1);
        resetn = 1'b0;
        #1;
        check("areset_immediate",
              {61'd0, biu_lsu_rd_pend, biu_rd_proto_err, axi_r_ready}, 64'd0);
        step();
        resetn = 1'b1;
        step();
        check("areset_ready_back", {63'd0, axi_r_ready}, 64'd1);
        check("areset_pend_zero", {63'd0, biu_lsu_rd_pend}, 64'd0);

        repeat (2) step();
        check("ifu_queue_drained", 64'(q_ifu.size()), 64'd0);
        check("lsu_queue_drained", 64'(q_lsu.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
